// File: rtl/led_matrix_scan.sv
// led_matrix_scan: column-multiplexed LED matrix driver.
// Scans NUM_ROWS x NUM_COLS one column at a time. The incoming frame is held in a
// shadow buffer until the next frame boundary, so a partly updated frame is never shown.
// Adds global PWM brightness and a frame_tick pulse for upstream pacing.
// Optional feature macro: LED_MATRIX_BLANK_EN adds anti-ghosting dead time at the
// start of every column slot.
// The row and column outputs are registered from the next-cycle values of the counters
// and buffers, so in any cycle they match the counter state of that same cycle.
module led_matrix_scan #(
  parameter int unsigned NUM_ROWS     = 8,
  parameter int unsigned NUM_COLS     = 4,
  parameter int unsigned COL_PERIOD   = 50_000,
  parameter int unsigned BRIGHT_BITS  = 4,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_ROWS*NUM_COLS-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BRIGHT_BITS-1:0]       brightness,
  output logic                         frame_tick,
  output logic [NUM_ROWS-1:0]          rows,
  output logic [NUM_COLS-1:0]          cols
);

  localparam int unsigned SLOT_W = (COL_PERIOD > 1) ? $clog2(COL_PERIOD) : 1;
  localparam int unsigned COL_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int unsigned FRAME_W = NUM_ROWS * NUM_COLS;

  // Scan and PWM state
  logic [SLOT_W-1:0]      r_slot_cnt;
  logic [COL_W-1:0]       r_col_idx;
  logic [BRIGHT_BITS-1:0] r_pwm_cnt;
  logic [BRIGHT_BITS-1:0] r_bright_q;

  // Frame buffers and handshake state
  logic [FRAME_W-1:0]     r_active;
  logic [FRAME_W-1:0]     r_shadow;
  logic                   r_pending;

  // Registered outputs
  logic [NUM_ROWS-1:0]    r_rows;
  logic [NUM_COLS-1:0]    r_cols;
  logic                   r_frame_tick;

  // Next-state values
  logic                   w_slot_last;
  logic                   w_col_last;
  logic                   w_boundary;
  logic [SLOT_W-1:0]      w_slot_next;
  logic [COL_W-1:0]       w_col_next;
  logic [BRIGHT_BITS-1:0] w_pwm_next;
  logic [BRIGHT_BITS-1:0] w_bright_next;
  logic                   w_xfer;
  logic                   w_swap;
  logic [FRAME_W-1:0]     w_active_next;
  logic                   w_tick_next;
  logic                   w_enable;
  logic                   w_blank;
  logic [NUM_ROWS-1:0]    w_col_pixels;
  logic [NUM_ROWS-1:0]    w_rows_next;
  logic [NUM_COLS-1:0]    w_cols_next;

  assign in_ready   = ~r_pending;
  assign frame_tick = r_frame_tick;
  assign rows       = r_rows;
  assign cols       = r_cols;

  // Compute scan counters, buffer swap and output pixel values for the next cycle
  always_comb begin
    w_slot_last   = (r_slot_cnt == SLOT_W'(COL_PERIOD - 1));
    w_col_last    = (r_col_idx == COL_W'(NUM_COLS - 1));
    w_boundary    = w_slot_last & w_col_last;

    w_slot_next   = w_slot_last ? '0 : r_slot_cnt + 1'b1;
    w_col_next    = r_col_idx;
    if (w_slot_last) begin
      w_col_next  = w_col_last ? '0 : r_col_idx + 1'b1;
    end
    w_pwm_next    = r_pwm_cnt + 1'b1;

    // Only one frame per ready window; a frame arriving on the boundary itself
    // lands in the shadow buffer and waits for the following boundary.
    w_xfer        = in_valid & ~r_pending;
    w_swap        = w_boundary & r_pending;
    w_active_next = w_swap ? r_shadow : r_active;
    w_bright_next = w_boundary ? brightness : r_bright_q;

    w_tick_next   = (w_slot_next == SLOT_W'(COL_PERIOD - 1)) &&
                    (w_col_next == COL_W'(NUM_COLS - 1));

    // All-ones brightness means always on; zero means always off
    w_enable      = (w_pwm_next < w_bright_next) | (&w_bright_next);

    w_col_pixels  = '0;
    for (int c = 0; c < int'(NUM_COLS); c++) begin
      if (w_col_next == COL_W'(c)) begin
        w_col_pixels = w_active_next[c*NUM_ROWS +: NUM_ROWS];
      end
    end

`ifdef LED_MATRIX_BLANK_EN
    w_blank       = (32'(w_slot_next) < BLANK_CYCLES);
`else
    // Blanking disabled: the term is forced low but keeps the parameter referenced
    w_blank       = 1'b0 & (32'(w_slot_next) < BLANK_CYCLES);
`endif

    w_rows_next   = ~(w_col_pixels & {NUM_ROWS{w_enable}});
    w_cols_next   = ~(NUM_COLS'(1) << w_col_next);
    if (w_blank) begin
      w_rows_next = '1;
      w_cols_next = '1;
    end
  end

  // Advance the column slot, column index and PWM counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_cnt <= '0;
      r_col_idx  <= '0;
      r_pwm_cnt  <= '0;
      r_bright_q <= '1;
    end else begin
      r_slot_cnt <= w_slot_next;
      r_col_idx  <= w_col_next;
      r_pwm_cnt  <= w_pwm_next;
      r_bright_q <= w_bright_next;
    end
  end

  // Accept frames into the shadow buffer and promote them at frame boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else begin
      r_active <= w_active_next;
      if (w_xfer) begin
        r_shadow  <= in_data;
        r_pending <= 1'b1;
      end else if (w_swap) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Register the board-facing drive and the frame tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rows       <= '1;
      r_cols       <= '1;
      r_frame_tick <= 1'b0;
    end else begin
      r_rows       <= w_rows_next;
      r_cols       <= w_cols_next;
      r_frame_tick <= w_tick_next;
    end
  end

endmodule

// File: doc/led_matrix_scan.md
Name: led_matrix_scan

Overview:
- Parametrised successor of the board's 8x4 LED matrix multiplexer.
- Scans an NUM_ROWS x NUM_COLS matrix one column at a time and double-buffers frame data behind a valid/ready handshake.
- Swaps frames only at frame boundaries, so no partial frame is ever displayed.
- Adds global PWM brightness and a frame_tick for upstream pacing.
- Sits between the top level (pattern/random source) and the ROWS/COLS board pins.

Parameters:
- NUM_ROWS, 8, number of row lines (pixels per column).
- NUM_COLS, 4, number of column lines (scan slots per frame).
- COL_PERIOD, 50_000, clock cycles each column is held; must be >= 2^BRIGHT_BITS.
- BRIGHT_BITS, 4, width of the brightness control.
- BLANK_CYCLES, 64, blanking cycles at the start of each column slot; used only with LED_MATRIX_BLANK_EN; must be < COL_PERIOD.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  NUM_ROWS*NUM_COLS  frame bitmap; pixel (r,c) = bit c*NUM_ROWS+r; 1 = lit.
- in_valid  in  1  in_data valid.
- in_ready  out  1  shadow buffer can accept a frame.
- brightness  in  BRIGHT_BITS  global duty; sampled at frame boundary.
- frame_tick  out  1  one-cycle pulse on the last cycle of each frame.
- rows  out  NUM_ROWS  active-low row drive; 0 = pixel lit.
- cols  out  NUM_COLS  active-low one-hot column select.

Behaviour:
- Reset (async assert, sync release): rows all 1; cols all 1; frame_tick 0; in_ready 1; active and shadow buffers 0; pending 0; col_idx 0; slot_cnt 0; pwm_cnt 0; bright_q all-ones.
- slot_cnt counts 0..COL_PERIOD-1 and wraps.
- On the wrap, col_idx advances and wraps NUM_COLS-1 -> 0.
- Frame boundary: the cycle where slot_cnt==COL_PERIOD-1 and col_idx==NUM_COLS-1. frame_tick is 1 exactly in that cycle, every frame, whether or not a swap occurs.
- cols is registered: bit col_idx = 0, all other bits 1. The first cycle after reset release drives column 0.
- PWM:
  - pwm_cnt is a free-running BRIGHT_BITS counter that increments every cycle.
  - Pixel enable = (pwm_cnt < bright_q) OR (bright_q == all-ones).
  - bright_q == 0 means fully dark.
- rows[r] = ~(active[col_idx*NUM_ROWS+r] & enable), registered. rows and cols change in the same cycle.
- Handshake:
  - Transfer occurs when in_valid & in_ready.
  - On transfer: shadow <= in_data, pending <= 1, in_ready <= 0 from the next cycle.
  - in_ready = ~pending.
- At the frame boundary:
  - If pending: active <= shadow and pending <= 0, so in_ready returns to 1 in the next cycle.
  - bright_q <= brightness, always.
  - The new frame displays from column 0.
- Simultaneous transfer and boundary with pending=0: the new frame is captured to shadow only. It is swapped at the next boundary, never mid-frame.
- Transfer while in_ready=0 is impossible; in_data is ignored.
- in_valid may be held high. Exactly one frame is taken per ready window.
- Reset mid-frame: everything returns to reset values immediately; rows and cols go to all 1 asynchronously.
- Counter widths: $clog2 of the respective range, minimum 1.

Optional Feature:
- Macro: LED_MATRIX_BLANK_EN.
- Defined: for slot_cnt < BLANK_CYCLES, cols = all 1 and rows = all 1 (anti-ghosting dead time). Column select and pixel data apply only for the remaining cycles of the slot. frame_tick timing is unchanged.
- Undefined: no blanking; BLANK_CYCLES is ignored; the column is driven for the full COL_PERIOD.

Test Plan (NUM_ROWS=8, NUM_COLS=4, COL_PERIOD=16, BRIGHT_BITS=2, BLANK_CYCLES=2 unless stated):
- Reset, then idle -> cols sequence 1110, 1101, 1011, 0111, 16 cycles each. frame_tick pulses every 64 cycles, in the cycle with slot_cnt 15 of column 3. rows=FF throughout (buffer 0). in_ready=1.
- Send 0x0000_00A5 with brightness=3 at cycle 10 -> in_ready drops the next cycle. Column 0 shows rows=0x5A starting the cycle after the first frame_tick. in_ready is 1 again one cycle after that frame_tick.
- Send a frame, then hold in_valid with a second frame -> the second frame is not accepted until in_ready reasserts. It is displayed exactly one frame after the first.
- brightness=1, frame all 1s -> in each column slot rows=00 for 1 of every 4 cycles (pwm_cnt==0), FF otherwise. brightness=0 -> rows constantly FF.
- Assert rst_n=0 mid column 2 -> rows and cols go all 1 the same cycle without a clock edge. After release the scan restarts at column 0 with a blank active buffer.
- With LED_MATRIX_BLANK_EN -> in each slot the first 2 cycles have cols=1111 and rows=FF, and the column is driven for 14 cycles. frame_tick period is still 64.
